// File: rtl/sample_trigger_pkg.sv
// Shared types and constants for the sample_trigger block.
//   state_t       : FSM states; their encoding is what state_out shows
//   TRIG_COUNT_W  : width of the trigger counter output
//   STATE_W       : width of state_out
//   drives_capture: true for the states in which the sampler runs
package sample_trigger_pkg;

    localparam int unsigned TRIG_COUNT_W = 16;
    localparam int unsigned STATE_W      = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // The sampler is released from reset only while capturing or holding results.
    function automatic logic drives_capture(input state_t st);
        return (st == ST_CAPTURE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/sample_trigger_match.sv
// trigger_match: masked compare of the probe word plus optional edge qualifier.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   clear           : arm accepted this cycle; restarts edge history
//   data_in         : live probe word
//   mask, value     : latched compare mask and required values
//   edge_en         : latched edge-mode select
//   hit_c           : combinational trigger qualifier for this cycle
// Macro SAMPLE_TRIGGER_EDGE_EN enables edge mode; otherwise edge_en is ignored.
module trigger_match #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [width-1:0] data_in,
    input  logic [width-1:0] mask,
    input  logic [width-1:0] value,
    input  logic             edge_en,
    output logic             hit_c
);

    logic match_c;

    // Only bits set in mask take part; mask of zero matches unconditionally.
    assign match_c = (((data_in ^ value) & mask) == '0);

`ifdef SAMPLE_TRIGGER_EDGE_EN
    logic prev_q, prev_d;
    logic valid_q, valid_d;

    // History restarts at arm: the first armed cycle only seeds prev, so a
    // level already present at arm time never counts as a rising match.
    always_comb begin
        prev_d  = match_c;
        valid_d = 1'b1;
        if (clear) begin
            prev_d  = 1'b0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            valid_q <= valid_d;
        end
    end

    assign hit_c = edge_en ? (match_c && valid_q && !prev_q) : match_c;
`else
    logic unused_edge;

    assign unused_edge = ^{clk, reset, clear, edge_en};
    assign hit_c       = match_c;
`endif

endmodule

// File: rtl/sample_trigger.sv
// sample_trigger: arms on request, waits for a masked match on the probe
// word, optionally delays, then releases the sampler and waits for it to
// report completion.
// Ports:
//   clk, reset        : sampler write clock, asynchronous active-high reset
//   data_in/data_out  : probe word and its one-cycle registered copy
//   arm, abort        : single-cycle control requests (abort has priority)
//   trig_mask/value   : compare mask and required values (latched on arm)
//   trig_delay        : cycles from match to capture start (latched on arm)
//   trig_edge         : edge-mode select (latched on arm)
//   samp_done         : sampler completion, honoured only in CAPTURE
//   samp_reset_n      : sampler reset, high in CAPTURE and DONE
//   state_out         : current state encoding
//   done_pulse        : one cycle on entry to DONE
//   trig_count        : triggers since reset, wrapping
// Macro SAMPLE_TRIGGER_EDGE_EN enables edge-mode matching.
module sample_trigger
    import sample_trigger_pkg::*;
#(
    parameter int unsigned width     = 32,
    parameter int unsigned delayBits = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [width-1:0]        data_in,
    output logic [width-1:0]        data_out,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [width-1:0]        trig_mask,
    input  logic [width-1:0]        trig_value,
    input  logic [delayBits-1:0]    trig_delay,
    input  logic                    trig_edge,
    input  logic                    samp_done,
    output logic                    samp_reset_n,
    output logic [STATE_W-1:0]      state_out,
    output logic                    done_pulse,
    output logic [TRIG_COUNT_W-1:0] trig_count
);

    state_t                  state_q, state_d;
    logic [width-1:0]        data_out_q, data_out_d;
    logic [width-1:0]        mask_q, mask_d;
    logic [width-1:0]        value_q, value_d;
    logic [delayBits-1:0]    delay_q, delay_d;
    logic                    edge_q, edge_d;
    logic [delayBits-1:0]    cnt_q, cnt_d;
    logic [TRIG_COUNT_W-1:0] trig_count_q, trig_count_d;
    logic                    samp_reset_n_q, samp_reset_n_d;
    logic                    done_pulse_q, done_pulse_d;
    logic                    arm_accept_c;
    logic                    hit_c;

    trigger_match #(.width(width)) u_match (
        .clk     (clk),
        .reset   (reset),
        .clear   (arm_accept_c),
        .data_in (data_in),
        .mask    (mask_q),
        .value   (value_q),
        .edge_en (edge_q),
        .hit_c   (hit_c)
    );

    // Next-state, counters and registered-output computation.
    always_comb begin
        state_d        = state_q;
        data_out_d     = data_in;
        mask_d         = mask_q;
        value_d        = value_q;
        delay_d        = delay_q;
        edge_d         = edge_q;
        cnt_d          = cnt_q;
        trig_count_d   = trig_count_q;
        arm_accept_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    arm_accept_c = 1'b1;
                    state_d      = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (hit_c) begin
                    trig_count_d = trig_count_q + TRIG_COUNT_W'(1);
                    if (delay_q == '0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = delay_q;
                    end
                end
            end
            ST_DELAY: begin
                // Counter holds the cycles left including this one.
                cnt_d = cnt_q - delayBits'(1);
                if (cnt_q == delayBits'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (samp_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (arm) begin
                    arm_accept_c = 1'b1;
                    state_d      = ST_ARMED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything decided above, including a trigger.
        if (abort) begin
            state_d      = ST_IDLE;
            arm_accept_c = 1'b0;
            trig_count_d = trig_count_q;
        end

        if (arm_accept_c) begin
            mask_d  = trig_mask;
            value_d = trig_value;
            delay_d = trig_delay;
            edge_d  = trig_edge;
        end

        samp_reset_n_d = drives_capture(state_d);
        done_pulse_d   = (state_q == ST_CAPTURE) && (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            data_out_q     <= '0;
            mask_q         <= '0;
            value_q        <= '0;
            delay_q        <= '0;
            edge_q         <= 1'b0;
            cnt_q          <= '0;
            trig_count_q   <= '0;
            samp_reset_n_q <= 1'b0;
            done_pulse_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_out_q     <= data_out_d;
            mask_q         <= mask_d;
            value_q        <= value_d;
            delay_q        <= delay_d;
            edge_q         <= edge_d;
            cnt_q          <= cnt_d;
            trig_count_q   <= trig_count_d;
            samp_reset_n_q <= samp_reset_n_d;
            done_pulse_q   <= done_pulse_d;
        end
    end

    assign data_out     = data_out_q;
    assign samp_reset_n = samp_reset_n_q;
    assign state_out    = state_q;
    assign done_pulse   = done_pulse_q;
    assign trig_count   = trig_count_q;

endmodule

// File: tb/tb_sample_trigger.sv
module tb_sample_trigger;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] trig_mask = '0;
    logic [31:0] trig_value = '0;
    logic [15:0] trig_delay = '0;
    logic        trig_edge = 1'b0;
    logic        samp_done = 1'b0;
    logic        samp_reset_n;
    logic [2:0]  state_out;
    logic        done_pulse;
    logic [15:0] trig_count;

    int total = 0;
    int bad   = 0;

    sample_trigger #(.width(32), .delayBits(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_out     (data_out),
        .arm          (arm),
        .abort        (abort),
        .trig_mask    (trig_mask),
        .trig_value   (trig_value),
        .trig_delay   (trig_delay),
        .trig_edge    (trig_edge),
        .samp_done    (samp_done),
        .samp_reset_n (samp_reset_n),
        .state_out    (state_out),
        .done_pulse   (done_pulse),
        .trig_count   (trig_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: states as plain ints, delay tracked as an absolute
    // release cycle rather than a countdown.
    int          cyc = 0;
    int          m_state = 0;      // 0 idle,1 armed,2 delay,3 capture,4 done
    int          m_release = 0;
    int          m_count = 0;
    logic [31:0] m_data_out = '0;
    logic        m_done_pulse = 1'b0;
    logic [31:0] m_mask = '0, m_value = '0;
    int          m_delay = 0;
    logic        m_edge = 1'b0;
    logic        m_prev = 1'b0;
    logic        m_prev_known = 1'b0;

    task automatic model_reset();
        m_state = 0; m_count = 0; m_data_out = '0; m_done_pulse = 1'b0;
        m_mask = '0; m_value = '0; m_delay = 0; m_edge = 1'b0;
        m_prev = 1'b0; m_prev_known = 1'b0;
    endtask

    task automatic model_latch();
        m_mask = trig_mask; m_value = trig_value; m_delay = int'(trig_delay); m_edge = trig_edge;
    endtask

    task automatic model_step();
        logic lvl, hit, accepted;
        cyc++;
        lvl = (((data_in ^ m_value) & m_mask) == 32'd0);
        hit = lvl;
`ifdef SAMPLE_TRIGGER_EDGE_EN
        if (m_edge) hit = lvl && m_prev_known && !m_prev;
`endif
        accepted = 1'b0;
        m_done_pulse = 1'b0;
        m_data_out = data_in;
        if (abort) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (arm) begin model_latch(); accepted = 1'b1; m_state = 1; end
                1: if (hit) begin
                    m_count = (m_count + 1) % 65536;
                    m_release = cyc + m_delay;
                    m_state = (m_delay == 0) ? 3 : 2;
                end
                2: if (cyc >= m_release) m_state = 3;
                3: if (samp_done) begin m_state = 4; m_done_pulse = 1'b1; end
                4: if (arm) begin model_latch(); accepted = 1'b1; m_state = 1; end
                default: m_state = 0;
            endcase
        end
        m_prev = accepted ? 1'b0 : lvl;
        m_prev_known = !accepted;
    endtask

    // Single compare process: model advances on each edge, DUT checked 1 unit later.
    always begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else model_step();
        #1;
        check("m_data_out", data_out, m_data_out);
        check("m_state", 32'(state_out), 32'(m_state));
        check("m_samp_reset_n", 32'(samp_reset_n), 32'((m_state == 3) || (m_state == 4)));
        check("m_done_pulse", 32'(done_pulse), 32'(m_done_pulse));
        check("m_trig_count", 32'(trig_count), 32'(m_count));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        step(); step();
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_srn", 32'(samp_reset_n), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_count", 32'(trig_count), 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        reset = 1'b0;
        step();

        // Level match, zero delay; mask change after arm must be ignored.
        trig_mask = 32'hFF; trig_value = 32'h5A; trig_delay = 16'd0; trig_edge = 1'b0;
        data_in = 32'h0; arm = 1'b1;
        step();
        arm = 1'b0; trig_mask = 32'h0;
        check("armed", 32'(state_out), 32'd1);
        step(); step();
        check("mask_latched", 32'(state_out), 32'd1);
        trig_mask = 32'hFF;
        data_in = 32'h5A;
        step();
        data_in = 32'h0;
        check("lvl_srn", 32'(samp_reset_n), 32'd1);
        check("lvl_count", 32'(trig_count), 32'd1);
        check("lvl_state", 32'(state_out), 32'd3);
        check("lvl_data_out", data_out, 32'h5A);

        // Completion and re-arm from DONE.
        samp_done = 1'b1;
        step();
        check("done_state", 32'(state_out), 32'd4);
        check("done_pulse_hi", 32'(done_pulse), 32'd1);
        step();
        samp_done = 1'b0;
        check("done_pulse_lo", 32'(done_pulse), 32'd0);
        check("done_hold", 32'(state_out), 32'd4);
        trig_delay = 16'd3; arm = 1'b1;
        step();
        arm = 1'b0;
        check("rearm_state", 32'(state_out), 32'd1);
        check("rearm_srn", 32'(samp_reset_n), 32'd0);

        // Delay of 3: DELAY for N+1..N+3, capture from N+4; arm ignored.
        data_in = 32'h5A;
        step();
        data_in = 32'h0; arm = 1'b1;
        check("dly_n1", 32'(state_out), 32'd2);
        step();
        arm = 1'b0;
        check("dly_n2", 32'(state_out), 32'd2);
        step();
        check("dly_n3", 32'(state_out), 32'd2);
        check("dly_n3_srn", 32'(samp_reset_n), 32'd0);
        step();
        check("dly_n4", 32'(state_out), 32'd3);
        check("dly_n4_srn", 32'(samp_reset_n), 32'd1);
        check("dly_count", 32'(trig_count), 32'd2);
        samp_done = 1'b1;
        step();
        samp_done = 1'b0;

        // Abort beats arm in DONE.
        arm = 1'b1; abort = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        check("abort_state", 32'(state_out), 32'd0);
        check("abort_srn", 32'(samp_reset_n), 32'd0);

        // Abort beats a match in ARMED: no trigger counted.
        trig_delay = 16'd0; arm = 1'b1;
        step();
        arm = 1'b0; data_in = 32'h5A; abort = 1'b1;
        step();
        abort = 1'b0; data_in = 32'h0;
        check("abort_match_count", 32'(trig_count), 32'd2);
        check("abort_match_state", 32'(state_out), 32'd0);

        // Delay of 1 boundary.
        trig_delay = 16'd1; arm = 1'b1;
        step();
        arm = 1'b0; data_in = 32'h5A;
        step();
        data_in = 32'h0;
        check("dly1_n1", 32'(state_out), 32'd2);
        step();
        check("dly1_n2", 32'(state_out), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Mask of zero matches any word.
        trig_mask = 32'h0; trig_delay = 16'd0; data_in = 32'h1234; arm = 1'b1;
        step();
        arm = 1'b0;
        step();
        check("mask0_state", 32'(state_out), 32'd3);
        check("mask0_count", 32'(trig_count), 32'd4);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Asynchronous reset in the middle of a long delay.
        trig_mask = 32'hFF; trig_value = 32'h5A; trig_delay = 16'd200; data_in = 32'h0; arm = 1'b1;
        step();
        arm = 1'b0; data_in = 32'h5A;
        step();
        data_in = 32'h0;
        repeat (100) step();
        check("pre_rst_state", 32'(state_out), 32'd2);
        #3 reset = 1'b1;
        #1;
        check("async_state", 32'(state_out), 32'd0);
        check("async_srn", 32'(samp_reset_n), 32'd0);
        check("async_count", 32'(trig_count), 32'd0);
        check("async_done", 32'(done_pulse), 32'd0);
        step();
        reset = 1'b0;
        repeat (5) step();
        check("post_rst_idle", 32'(state_out), 32'd0);

        // Edge mode: held match across arm must not trigger when enabled.
        trig_mask = 32'hFF; trig_value = 32'h5A; trig_delay = 16'd0; trig_edge = 1'b1;
        data_in = 32'h5A; arm = 1'b1;
        step();
        arm = 1'b0;
        step(); step(); step();
`ifdef SAMPLE_TRIGGER_EDGE_EN
        check("edge_held", 32'(state_out), 32'd1);
`else
        check("edge_ignored", 32'(state_out), 32'd3);
`endif
        data_in = 32'h0;
        step();
        data_in = 32'h5A;
        step();
        check("edge_trig_state", 32'(state_out), 32'd3);
        check("edge_trig_count", 32'(trig_count), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_trigger.md
SAMPLE_TRIGGER -- requirements
Module: sample_trigger

Interface
REQ-001 Parameter width, default 32: data word width in bits.
REQ-002 Parameter delayBits, default 16: width of the post-trigger delay count.
REQ-003 Port clk, input, 1: sole clock; it is the sampler write clock.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port data_in, input, width: raw probe word.
REQ-006 Port data_out, output, width: data_in registered once; feeds sampler w_in.
REQ-007 Port arm, input, 1: single-cycle request to arm the trigger.
REQ-008 Port abort, input, 1: single-cycle request to return to IDLE.
REQ-009 Port trig_mask, input, width: bits that take part in the compare.
REQ-010 Port trig_value, input, width: required values of the masked bits.
REQ-011 Port trig_delay, input, delayBits: cycles from match to capture start.
REQ-012 Port trig_edge, input, 1: selects edge-mode match.
REQ-013 Port samp_done, input, 1: sampler w_done.
REQ-014 Port samp_reset_n, output, 1: drives sampler w_reset_n.
REQ-015 Port state_out, output, 3: current state encoding.
REQ-016 Port done_pulse, output, 1: one-cycle pulse on capture completion.
REQ-017 Port trig_count, output, 16: number of triggers since reset; wraps.

Function
REQ-018 data_out SHALL equal data_in delayed by exactly 1 clk in every state.
- This aligns the sampled word with the samp_reset_n timing.
REQ-019 match SHALL be true when ((data_in XOR trig_value) AND trig_mask) is zero.
- trig_mask = 0 therefore matches on every cycle.
REQ-020 States SHALL be IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4; the encoding is visible on state_out.
REQ-021 IDLE SHALL drive samp_reset_n=0; arm moves the block to ARMED.
REQ-022 On each arm acceptance, the block SHALL latch trig_mask, trig_value, trig_delay and trig_edge into internal registers.
- Input changes after that have no effect until the next arm.
REQ-023 ARMED SHALL drive samp_reset_n=0.
- On a match with latched delay=0: go to CAPTURE.
- On a match with latched delay>0: go to DELAY and load the counter with the latched delay.
REQ-024 DELAY SHALL decrement the counter once per cycle and go to CAPTURE in the cycle the counter reaches 1.
- Match cycle N therefore gives samp_reset_n=1 from cycle N+1+delay.
REQ-025 CAPTURE and DONE SHALL drive samp_reset_n=1.
- CAPTURE goes to DONE on the first cycle samp_done=1.
REQ-026 done_pulse SHALL be 1 for exactly the single cycle in which DONE is entered.
REQ-027 trig_count SHALL increment by 1 on each ARMED-to-DELAY or ARMED-to-CAPTURE transition, wrapping from 65535 to 0.
REQ-028 In DONE, arm SHALL move the block to ARMED; samp_reset_n drops to 0 the next cycle, which rewinds the sampler.
REQ-029 arm SHALL be ignored in ARMED, DELAY and CAPTURE.
REQ-030 abort SHALL move any state to IDLE on the next cycle.
- When abort and arm occur in the same cycle, abort wins.
REQ-031 samp_done=1 SHALL be ignored in every state except CAPTURE.

Reset
REQ-032 Asserting reset SHALL immediately force the following, with no clock required:
- state IDLE, samp_reset_n=0;
- data_out, counter, trig_count, done_pulse and the latched registers to 0.
REQ-033 Reset asserted mid-DELAY or mid-CAPTURE SHALL abandon the capture; no done_pulse is produced.

Configuration
REQ-034 Macro SAMPLE_TRIGGER_EDGE_EN, when defined, enables edge mode as follows.
- Applies only when the latched trig_edge=1.
- A match counts only if match is 1 this cycle and was 0 in the previous cycle.
- The previous-match register is cleared on arm acceptance.
REQ-035 When SAMPLE_TRIGGER_EDGE_EN is undefined, trig_edge SHALL still exist as a port but be ignored, and matching is level-only.

Structure
REQ-036 Package sample_trigger_pkg SHALL hold the state enum, the state_out encodings and the trig_count width constant (16).
REQ-037 The match compare and the edge-mode previous-match register SHALL live in one sub-module, trigger_match.

Verification
REQ-038 Level match, zero delay:
- Setup: mask=0xFF, value=0x5A, delay=0, arm; data_in=0x5A at cycle N.
- Required: samp_reset_n=1 at N+1; trig_count=1.
REQ-039 Delay:
- Setup: delay=3; match at cycle N.
- Required: state DELAY for cycles N+1..N+3, samp_reset_n=1 from N+4.
REQ-040 Completion:
- Stimulus: samp_done=1 during CAPTURE.
- Required: DONE, done_pulse high for exactly 1 cycle.
- Then arm: samp_reset_n=0 the next cycle, state ARMED.
REQ-041 Abort priority:
- Stimulus: arm and abort in the same cycle while in DONE.
- Required: IDLE, samp_reset_n=0.
REQ-042 Edge mode, with the macro defined:
- Setup: trig_edge=1; data_in held at 0x5A across arm.
- Required: no trigger while 0x5A is held; trigger only after data_in goes 0x00 then 0x5A.
REQ-043 Asynchronous reset in DELAY with counter=100:
- Required: IDLE and samp_reset_n=0 before the next clk edge.
- Required: trig_count=0 and no done_pulse.
